// File: rtl/tile_map_engine.sv
// Pixel-to-tile lookup engine: a 2-stage pipelined tile map with a self-clearing fill FSM.
// Optional macro TILE_MAP_GRID_LINE_EN flags tile-boundary pixels as grid lines.
module tile_map_engine #(
    parameter int TILE_W    = 32,
    parameter int TILE_H    = 30,
    parameter int COLS      = 20,
    parameter int ROWS      = 16,
    parameter int TYPE_W    = 4,
    parameter int FILL_TYPE = 0,
    parameter int OOB_TYPE  = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                x,
    input  logic [8:0]                y,
    input  logic                      px_valid,
    input  logic                      wr_en,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [TYPE_W-1:0]         wr_type,
    input  logic                      clear_req,
    output logic [TYPE_W-1:0]         tile_type,
    output logic                      tile_valid,
    output logic                      grid_line,
    output logic                      busy
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [9:0]        TW_X   = 10'(TILE_W);
    localparam logic [9:0]        COLS_X = 10'(COLS);
    localparam logic [8:0]        TH_Y   = 9'(TILE_H);
    localparam logic [8:0]        ROWS_Y = 9'(ROWS);
    localparam logic [CW:0]       COLS_W = (CW+1)'(COLS);
    localparam logic [RW:0]       ROWS_W = (RW+1)'(ROWS);
    localparam logic [AW-1:0]     COLS_A = AW'(COLS);
    localparam logic [AW-1:0]     LAST_A = AW'(DEPTH - 1);
    localparam logic [TYPE_W-1:0] FILL_L = TYPE_W'(FILL_TYPE);
    localparam logic [TYPE_W-1:0] OOB_L  = TYPE_W'(OOB_TYPE);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     cnt_reg, cnt_next;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [TYPE_W-1:0] mem_wdata;
    logic              wr_ok;

    logic [TYPE_W-1:0] mem [DEPTH];
    logic [TYPE_W-1:0] rd_data_reg;
    logic [AW-1:0]     rd_addr;

    logic [9:0]        x_col;
    logic [8:0]        y_row;
    logic              grid_hit;
    logic              s1_valid_reg, s1_inr_reg, s1_grid_reg;
    logic [CW-1:0]     s1_col_reg;
    logic [RW-1:0]     s1_row_reg;
    logic              s2_valid_reg, s2_oob_reg, s2_grid_reg, s2_busy_reg;

    // Constant divisors: synthesis folds these into fixed combinational logic.
    assign x_col = x / TW_X;
    assign y_row = y / TH_Y;

`ifdef TILE_MAP_GRID_LINE_EN
    assign grid_hit = ((x % TW_X) == '0) || ((y % TH_Y) == '0);
`else
    assign grid_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_inr_reg   <= 1'b0;
            s1_grid_reg  <= 1'b0;
            s1_col_reg   <= '0;
            s1_row_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_oob_reg   <= 1'b0;
            s2_grid_reg  <= 1'b0;
            s2_busy_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= px_valid;
            s1_inr_reg   <= (x_col < COLS_X) && (y_row < ROWS_Y);
            s1_grid_reg  <= grid_hit;
            s1_col_reg   <= x_col[CW-1:0];
            s1_row_reg   <= y_row[RW-1:0];
            s2_valid_reg <= s1_valid_reg;
            s2_oob_reg   <= !s1_inr_reg;
            s2_grid_reg  <= s1_grid_reg;
            s2_busy_reg  <= busy;
        end
    end

    // Off-map coordinates read entry 0; the result is overridden with OOB_TYPE anyway.
    assign rd_addr = s1_inr_reg ? (AW'(s1_row_reg) * COLS_A + AW'(s1_col_reg)) : '0;

    // Registered read sees the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign wr_ok = ({1'b0, wr_col} < COLS_W) && ({1'b0, wr_row} < ROWS_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_we     = 1'b0;
        mem_waddr  = cnt_reg;
        mem_wdata  = FILL_L;
        unique case (state_reg)
            CLEAR: begin
                mem_we = 1'b1;
                if (cnt_reg == LAST_A) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else if (wr_en && wr_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = AW'(wr_row) * COLS_A + AW'(wr_col);
                    mem_wdata = wr_type;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy       = (state_reg == CLEAR);
    assign tile_valid = s2_valid_reg;

    // Priority: grid line, then fill-in-progress, then off-map, then stored entry.
    always_comb begin
        tile_type = '0;
        grid_line = 1'b0;
        if (s2_valid_reg) begin
            if (s2_grid_reg) begin
                grid_line = 1'b1;
            end else if (s2_busy_reg) begin
                tile_type = FILL_L;
            end else if (s2_oob_reg) begin
                tile_type = OOB_L;
            end else begin
                tile_type = rd_data_reg;
            end
        end
    end
endmodule

// File: doc/tile_map_engine.md
TILE_MAP_ENGINE -- requirements
Module: tile_map_engine

Interface
REQ-001 Parameter TILE_W, default 32, tile width in pixels.
REQ-002 Parameter TILE_H, default 30, tile height in pixels.
REQ-003 Parameter COLS, default 20, and ROWS, default 16, give the grid size in tiles.
REQ-004 Parameter TYPE_W, default 4, is the tile-type code width; FILL_TYPE, default 0, is the clear value; OOB_TYPE, default 15, is the off-map code.
REQ-005 clk  input  1  the single clock; all logic is rising-edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 x  input  10, y  input  9  pixel coordinate to look up.
REQ-008 px_valid  input  1  a lookup request this cycle.
REQ-009 wr_en  input  1, wr_col  input  clog2(COLS), wr_row  input  clog2(ROWS), wr_type  input  TYPE_W  tile write port.
REQ-010 clear_req  input  1  a one-cycle pulse that starts a full-map fill with FILL_TYPE.
REQ-011 tile_type  output  TYPE_W, tile_valid  output  1, grid_line  output  1  lookup result.
REQ-012 busy  output  1  high while a fill is in progress.

Function
REQ-013 Tile storage SHALL be a COLS*ROWS array of TYPE_W entries, addressed as row*COLS+col.
REQ-014 Lookup SHALL be a 2-stage pipeline.
- Stage 1 registers col=x/TILE_W, row=y/TILE_H and an in-range flag.
- Stage 2 reads the array.
- tile_valid equals px_valid delayed exactly 2 cycles; outputs are fully pipelined (one result per cycle).
REQ-015 If col>=COLS or row>=ROWS, tile_type SHALL be OOB_TYPE, with tile_valid still following px_valid.
REQ-016 When tile_valid=0, tile_type and grid_line SHALL be 0.
REQ-017 The FSM SHALL have states CLEAR and IDLE.
- CLEAR writes FILL_TYPE to one entry per cycle, addresses 0..COLS*ROWS-1 ascending.
- CLEAR moves to IDLE after the last entry.
- IDLE moves to CLEAR on clear_req.
REQ-018 busy SHALL be 1 exactly while in CLEAR.
REQ-019 While busy=1:
- wr_en and clear_req are ignored.
- A valid lookup returns tile_type=FILL_TYPE.
REQ-020 In IDLE, wr_en with wr_col<COLS and wr_row<ROWS SHALL update the entry at the clock edge; out-of-range writes are dropped silently.
REQ-021 If clear_req and wr_en are both asserted in IDLE in the same cycle, the clear SHALL win and the write SHALL be dropped.
REQ-022 If a write and a stage-2 read hit the same entry in the same cycle, the read SHALL return the old value (read-before-write).
REQ-023 Pixel division SHALL use constant parameters only; no runtime divider and no multi-cycle arithmetic.

Reset
REQ-024 While reset_n=0, the block SHALL hold these values:
- tile_valid=0, tile_type=0, grid_line=0, busy=1.
- Pipeline valid bits cleared.
- FSM in CLEAR with the fill counter at 0.
REQ-025 On reset_n release, the block SHALL perform a full fill (COLS*ROWS cycles) before busy drops.
REQ-026 Reset asserted mid-fill SHALL restart the fill from address 0 after release.

Configuration
REQ-027 Macro TILE_MAP_GRID_LINE_EN SHALL control boundary-pixel handling.
- Defined: a valid lookup with x%TILE_W==0 or y%TILE_H==0 gives grid_line=1 and tile_type=0, and in-range/OOB decoding is otherwise unchanged.
- Undefined: grid_line is constant 0 and boundary pixels report their own tile's type.

Verification
REQ-028 Release reset -> busy=1 for exactly 320 cycles, then 0; a lookup at (100,100) returns tile_type=0.
REQ-029 In IDLE, write col=1,row=0,type=3, then lookup (42,20) -> 2 cycles later tile_valid=1, tile_type=3.
REQ-030 Lookup (64,20) -> macro defined: grid_line=1, tile_type=0; undefined: grid_line=0, tile_type equals the entry at col 2, row 0.
REQ-031 Lookup (650,10) -> tile_type=15; lookup (639,479) -> in-range entry at col 19, row 15.
REQ-032 clear_req and wr_en (col 5, row 5, type 7) in the same cycle -> busy for 320 cycles; a later lookup (170,160) returns 0.
REQ-033 Assert reset_n=0 at fill count 100 -> busy=1 and tile_valid=0 immediately; after release, busy lasts a full 320 cycles.
